// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control sequencer (IF/ID/EX/MEM/WB/HALT) with
// retired-instruction counter and sticky illegal-opcode trap.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       OP,
  input  logic [5:0]       func,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic [1:0]       PC_src,
  output logic [1:0]       Reg_dst,
  output logic [3:0]       ALUOP,
  output logic             ALU_src,
  output logic [2:0]       Shift_ctrl,
  output logic [1:0]       MtoR,
  output logic [1:0]       s_type,
  output logic             RWE,
  output logic             MWE,
  output logic             Branch,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             err
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7
  } state_t;
  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_SLL, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_t;
  function automatic cls_t decode(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = C_ILL;
    case (op)
      6'h00: c = fn == 6'h21 ? C_ADDU : fn == 6'h23 ? C_SUBU : fn == 6'h00 ? C_SLL : fn == 6'h08 ? C_JR : C_ILL;
      6'h0D: c = C_ORI;
      6'h0F: c = C_LUI;
      6'h23: c = C_LW;
      6'h2B: c = C_SW;
      6'h04: c = C_BEQ;
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction
  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d, func_q, func_d;
  logic [3:0]       aluop_q, aluop_d;
  logic             alu_src_q, alu_src_d;
  logic [2:0]       shift_q, shift_d;
  logic [1:0]       reg_dst_q, reg_dst_d, mtor_q, mtor_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             err_q, err_d;
  cls_t             cls, in_cls;
  logic             in_if, in_id, in_ex, in_mem, in_wb;
  assign cls    = decode(op_q, func_q);
  assign in_cls = decode(OP, func);
  assign in_if  = state_q == S_IF;
  assign in_id  = state_q == S_ID;
  assign in_ex  = state_q == S_EX;
  assign in_mem = state_q == S_MEM;
  assign in_wb  = state_q == S_WB;
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    func_d    = func_q;
    aluop_d   = aluop_q;
    alu_src_d = alu_src_q;
    shift_d   = shift_q;
    reg_dst_d = reg_dst_q;
    mtor_d    = mtor_q;
    err_d     = err_q;
    case (state_q)
      S_IF: state_d = run ? S_ID : S_IF;
      S_ID: begin
        op_d      = OP;
        func_d    = func;
        aluop_d   = in_cls inside {C_SUBU, C_BEQ} ? 4'd1 : in_cls == C_SLL ? 4'd3 :
                    in_cls == C_ORI ? 4'd2 : in_cls inside {C_LUI, C_JR} ? 4'd4 : 4'd0;
        alu_src_d = in_cls inside {C_ORI, C_LUI, C_LW, C_SW};
        shift_d   = in_cls == C_LUI ? 3'd2 : in_cls inside {C_LW, C_SW, C_BEQ} ? 3'd1 : 3'd0;
        reg_dst_d = in_cls inside {C_ADDU, C_SUBU, C_SLL} ? 2'd1 : in_cls == C_JAL ? 2'd2 : 2'd0;
        mtor_d    = in_cls == C_LW ? 2'd1 : in_cls == C_JAL ? 2'd2 : 2'd0;
        err_d     = err_q | (in_cls == C_ILL);
        state_d   = in_cls == C_J ? S_IF : in_cls == C_JAL ? S_WB : in_cls == C_ILL ? S_HALT : S_EX;
      end
      S_EX:  state_d = cls inside {C_BEQ, C_JR} ? S_IF : cls inside {C_LW, C_SW} ? S_MEM : S_WB;
      S_MEM: state_d = !mem_ready ? S_MEM : cls == C_LW ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_HALT;
    endcase
  end
  // Enables are gated by reset so nothing fires while reset is held, even in IF.
  always_comb begin
    IR_WE  = !reset && in_if && run;
    PC_WE  = !reset && ((in_id && in_cls == C_J) || (in_ex && cls inside {C_BEQ, C_JR}) ||
                        (in_mem && cls == C_SW && mem_ready) || in_wb);
    RWE    = !reset && in_wb;
    MWE    = !reset && in_mem && cls == C_SW && mem_ready;
    Branch = !reset && in_ex && cls == C_BEQ;
    PC_src = reset ? 2'd0 : (in_id && in_cls == C_J) ? 2'd2 : (in_ex && cls == C_BEQ) ? {1'b0, Zero} :
             (in_ex && cls == C_JR) ? 2'd3 : (in_wb && cls == C_JAL) ? 2'd2 : 2'd0;
    instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, PC_WE};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IF;
      op_q        <= '0;
      func_q      <= '0;
      aluop_q     <= '0;
      alu_src_q   <= 1'b0;
      shift_q     <= '0;
      reg_dst_q   <= '0;
      mtor_q      <= '0;
      instr_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      func_q      <= func_d;
      aluop_q     <= aluop_d;
      alu_src_q   <= alu_src_d;
      shift_q     <= shift_d;
      reg_dst_q   <= reg_dst_d;
      mtor_q      <= mtor_d;
      instr_cnt_q <= instr_cnt_d;
      err_q       <= err_d;
    end
  end
  assign ALUOP      = aluop_q;
  assign ALU_src    = alu_src_q;
  assign Shift_ctrl = shift_q;
  assign Reg_dst    = reg_dst_q;
  assign MtoR       = mtor_q;
  assign s_type     = 2'd0;
  assign state      = state_q;
  assign instr_cnt  = instr_cnt_q;
  assign err        = err_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream against a per-instruction cycle
// model; a 3-bit-counter twin instance exercises counter wrap.
module tb_mc_ctrl;
  logic clk = 0, reset = 1, run = 0, Zero = 0, mem_ready = 0;
  logic [5:0] OP = 0, func = 0;
  logic IR_WE, PC_WE, ALU_src, RWE, MWE, Branch, err;
  logic [1:0] PC_src, Reg_dst, MtoR, s_type;
  logic [3:0] ALUOP;
  logic [2:0] Shift_ctrl, state;
  logic [31:0] instr_cnt;
  logic s_ir, s_pcwe, s_src, s_rwe, s_mwe, s_br, s_err;
  logic [1:0] s_pcsrc, s_rd, s_mtor, s_st;
  logic [3:0] s_aluop;
  logic [2:0] s_sh, s_state, s_cnt;
  int n_cmp = 0, n_err = 0, cnt = 0;
  int ops[11] = '{0, 0, 0, 0, 13, 15, 35, 43, 4, 2, 3};
  int fns[11] = '{33, 35, 0, 8, 0, 0, 0, 0, 0, 0, 0};

  mc_ctrl dut (.clk(clk), .reset(reset), .run(run), .OP(OP), .func(func), .Zero(Zero),
    .mem_ready(mem_ready), .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_src(PC_src), .Reg_dst(Reg_dst),
    .ALUOP(ALUOP), .ALU_src(ALU_src), .Shift_ctrl(Shift_ctrl), .MtoR(MtoR), .s_type(s_type),
    .RWE(RWE), .MWE(MWE), .Branch(Branch), .state(state), .instr_cnt(instr_cnt), .err(err));
  mc_ctrl #(.CNT_W(3)) dut_s (.clk(clk), .reset(reset), .run(run), .OP(OP), .func(func),
    .Zero(Zero), .mem_ready(mem_ready), .IR_WE(s_ir), .PC_WE(s_pcwe), .PC_src(s_pcsrc),
    .Reg_dst(s_rd), .ALUOP(s_aluop), .ALU_src(s_src), .Shift_ctrl(s_sh), .MtoR(s_mtor),
    .s_type(s_st), .RWE(s_rwe), .MWE(s_mwe), .Branch(s_br), .state(s_state),
    .instr_cnt(s_cnt), .err(s_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ir"}, IR_WE, 0);
    chk({tag, "_pcwe"}, PC_WE, 0);
    chk({tag, "_rwe"}, RWE, 0);
    chk({tag, "_mwe"}, MWE, 0);
    chk({tag, "_br"}, Branch, 0);
  endtask

  // One instruction from IF to retirement; expected cycles come from the instruction class.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int stalls, input int idle);
    int seq[$];
    int mk = 0;
    bit rt = op == 0, is_j = op == 2, is_jal = op == 3, is_beq = op == 4;
    bit is_lw = op == 6'h23, is_sw = op == 6'h2B, is_ori = op == 6'h0D, is_lui = op == 6'h0F;
    bit is_jr = rt && fn == 8;
    bit arith = (rt && !is_jr) || is_ori || is_lui;
    bit wr = arith || is_lw || is_jal;
    logic [1:0] psrc = (is_j || is_jal) ? 2'd2 : is_jr ? 2'd3 : is_beq ? {1'b0, z} : 2'd0;
    logic [3:0] ex_alu = rt ? (fn == 6'h23 ? 4'd1 : fn == 0 ? 4'd3 : is_jr ? 4'd4 : 4'd0) :
                         is_ori ? 4'd2 : is_lui ? 4'd4 : is_beq ? 4'd1 : 4'd0;
    logic [2:0] ex_sh = is_lui ? 3'd2 : (is_lw || is_sw || is_beq) ? 3'd1 : 3'd0;
    seq = {0, 1};
    if (is_jal) seq.push_back(4);
    else if (!is_j) begin
      seq.push_back(2);
      if (is_lw || is_sw) repeat (stalls + 1) seq.push_back(3);
      if (is_lw || arith) seq.push_back(4);
    end
    repeat (idle) begin
      @(negedge clk);
      run = 0; OP = 6'($urandom); mem_ready = 1'($urandom);
      #1 chk("idle_state", state, 0);
      chk_quiet("idle");
    end
    for (int k = 0; k < seq.size(); k++) begin
      bit last = k == seq.size() - 1;
      @(negedge clk);
      run = k == 0 ? 1'b1 : 1'($urandom);
      OP = k <= 1 ? op : 6'($urandom);
      func = (k <= 1 && rt) ? fn : 6'($urandom);
      Zero = last ? z : 1'($urandom);
      mem_ready = seq[k] == 3 ? (mk >= stalls) : 1'($urandom);
      if (seq[k] == 3) mk++;
      #1;
      if (k == 0) begin
        chk("cnt", instr_cnt, cnt);
        chk("cnt_wrap3", s_cnt, 32'(cnt % 8));
        chk("err_clear", err, 0);
      end
      chk("state", state, seq[k]);
      chk("ir_we", IR_WE, k == 0);
      chk("pc_we", PC_WE, last);
      chk("rwe", RWE, last && wr);
      chk("mwe", MWE, last && is_sw);
      chk("branch", Branch, last && is_beq);
      if (last) chk("pc_src", PC_src, psrc);
      if (seq[k] == 2) begin
        chk("ex_aluop", ALUOP, ex_alu);
        if (!is_beq && !is_jr) chk("ex_alu_src", ALU_src, is_ori || is_lui || is_lw || is_sw);
        if (!rt) chk("ex_shift", Shift_ctrl, ex_sh);
      end
      if (last && wr) begin
        chk("wb_reg_dst", Reg_dst, is_jal ? 2 : rt ? 1 : 0);
        if (!is_ori && !is_lui) chk("wb_mtor", MtoR, is_jal ? 2 : is_lw ? 1 : 0);
      end
      if (last) cnt++;
    end
  endtask

  initial begin
    run = 1;
    #2;
    chk("rst_state", state, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_err", err, 0);
    chk_quiet("rst");
    chk("rst_sel", {PC_src, Reg_dst, ALUOP, ALU_src, Shift_ctrl, MtoR}, 0);
    run = 0;
    @(negedge clk) reset = 0;
    do_instr(6'h00, 6'h21, 0, 0, 1);
    do_instr(6'h23, 6'h00, 0, 2, 0);
    do_instr(6'h04, 6'h00, 1, 0, 0);
    do_instr(6'h04, 6'h00, 0, 0, 2);
    do_instr(6'h03, 6'h00, 0, 0, 0);
    do_instr(6'h02, 6'h00, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      int s = $urandom_range(10);
      do_instr(6'(ops[s]), ops[s] == 0 ? 6'(fns[s]) : 6'($urandom), 1'($urandom),
               $urandom_range(3), $urandom_range(2));
    end
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      run = 1; OP = t == 0 ? 6'h3F : 6'h00; func = t == 0 ? 6'($urandom) : 6'h3F;
      #1 chk("ill_if", state, 0);
      @(negedge clk);
      run = 1'($urandom);
      #1 chk("ill_id", state, 1);
      chk("ill_id_pcwe", PC_WE, 0);
      repeat (3) begin
        @(negedge clk);
        run = 1'($urandom); OP = 6'($urandom); mem_ready = 1'($urandom); Zero = 1'($urandom);
        #1 chk("halt_state", state, 7);
        chk("halt_err", err, 1);
        chk("halt_cnt", instr_cnt, cnt);
        chk_quiet("halt");
      end
      run = 1;
      #2 reset = 1;
      #1 chk("rst_halt_state", state, 0);
      chk("rst_halt_err", err, 0);
      chk("rst_halt_cnt", instr_cnt, 0);
      chk("rst_halt_ir", IR_WE, 0);
      @(negedge clk);
      reset = 0; run = 0; cnt = 0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      run = k == 0; OP = 6'h2B; mem_ready = 0;
      #1 chk("sw_state", state, k == 3 ? 3 : k);
    end
    chk("sw_mem_mwe", MWE, 0);
    #1 reset = 1; mem_ready = 1;
    #1 chk("sw_rst_mwe", MWE, 0);
    chk("sw_rst_pcwe", PC_WE, 0);
    chk("sw_rst_state", state, 0);
    @(negedge clk);
    chk("sw_rst_cnt", instr_cnt, 0);
    reset = 0; run = 0; cnt = 0;
    do_instr(6'h2B, 6'h00, 0, 1, 0);
    do_instr(6'h0F, 6'h00, 0, 0, 0);
    do_instr(6'h00, 6'h08, 0, 0, 1);
    @(negedge clk);
    #1 chk("final_cnt", instr_cnt, cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
